// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings used by both transmitter and receiver,
// parity mode constants and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      TX_START_BIT  = 3'd1,
      TX_DATA_BITS  = 3'd2,
      TX_PARITY_BIT = 3'd3,
      TX_STOP_BIT   = 3'd4,
      CLEANUP       = 3'd5
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Even parity is the plain XOR of the data; odd parity is its inverse.
   function automatic logic parity_of(input logic [7:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts clock cycles within one UART bit and pulses o_Bit_Tick on the last
// cycle of each bit; reusable by the receiver.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Bit_Tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] bit_count;

   // The count restarts at zero on every bit boundary and never runs past terminal.
   always_ff @(posedge i_Clock) begin
      if (i_Reset || i_Clear) begin
         bit_count <= '0;
      end else if (i_Enable) begin
         if (bit_count == TERMINAL) begin
            bit_count <= '0;
         end else begin
            bit_count <= bit_count + 1'b1;
         end
      end
   end

   assign o_Bit_Tick = i_Enable && (bit_count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits. All outputs are registered from the next-state decode.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int PARITY       = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Serial,
   output logic       o_TX_Active,
   output logic       o_TX_Ready,
   output logic       o_TX_Done
);

   uart_state_t state;
   uart_state_t state_next;

   logic [2:0] bit_index;
   logic [2:0] bit_index_next;
   logic       stop_index;
   logic       stop_index_next;
   logic [7:0] tx_data;
   logic       parity_bit;
   logic       load_byte;
   logic       bit_tick;
   logic       timer_enable;

   logic serial_next;
   logic active_next;
   logic ready_next;
   logic done_next;

   assign timer_enable = (state != IDLE) && (state != CLEANUP);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .i_Clear   (!timer_enable),
      .i_Enable  (timer_enable),
      .o_Bit_Tick(bit_tick)
   );

   // Next-state decode; every transition inside a frame happens on a bit tick.
   always_comb begin
      state_next      = state;
      bit_index_next  = bit_index;
      stop_index_next = stop_index;
      load_byte       = 1'b0;
      case (state)
         IDLE: begin
            if (i_TX_DV) begin
               load_byte       = 1'b1;
               state_next      = TX_START_BIT;
               bit_index_next  = 3'd0;
               stop_index_next = 1'b0;
            end
         end
         TX_START_BIT: begin
            if (bit_tick) begin
               state_next = TX_DATA_BITS;
            end
         end
         TX_DATA_BITS: begin
            if (bit_tick) begin
               if (bit_index == 3'd7) begin
                  bit_index_next = 3'd0;
                  state_next     = (PARITY != PARITY_NONE) ? TX_PARITY_BIT : TX_STOP_BIT;
               end else begin
                  bit_index_next = bit_index + 3'd1;
               end
            end
         end
         TX_PARITY_BIT: begin
            if (bit_tick) begin
               state_next = TX_STOP_BIT;
            end
         end
         TX_STOP_BIT: begin
            if (bit_tick) begin
               if ((STOP_BITS == 2) && !stop_index) begin
                  stop_index_next = 1'b1;
               end else begin
                  state_next = CLEANUP;
               end
            end
         end
         CLEANUP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so they can be registered
   // without adding a cycle of latency.
   always_comb begin
      serial_next = 1'b1;
      case (state_next)
         TX_START_BIT:  serial_next = 1'b0;
         TX_DATA_BITS:  serial_next = tx_data[bit_index_next];
         TX_PARITY_BIT: serial_next = parity_bit;
         default:       serial_next = 1'b1;
      endcase
      active_next = (state_next != IDLE) && (state_next != CLEANUP);
      ready_next  = (state_next == IDLE);
      done_next   = (state_next == CLEANUP);
   end

   // Reset takes priority over an accept in the same cycle.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= IDLE;
         bit_index   <= 3'd0;
         stop_index  <= 1'b0;
         tx_data     <= 8'h00;
         parity_bit  <= 1'b0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Ready  <= 1'b1;
         o_TX_Done   <= 1'b0;
      end else begin
         state       <= state_next;
         bit_index   <= bit_index_next;
         stop_index  <= stop_index_next;
         if (load_byte) begin
            tx_data    <= i_TX_Byte;
            parity_bit <= parity_of(i_TX_Byte, PARITY);
         end
         o_TX_Serial <= serial_next;
         o_TX_Active <= active_next;
         o_TX_Ready  <= ready_next;
         o_TX_Done   <= done_next;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three parameter sets driven with random traffic,
// frames checked bit-for-bit against waveforms built from the framing rules.
module tb_uart_tx;

   typedef struct {
      logic [7:0] b;
      int         n;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int finishedCount = 0;

   task automatic checkOutput(input string name, input int inst, input longint actual,
                              input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s (cfg %0d) at cycle %0d: got %0d, want %0d",
                  name, inst, cyc, actual, expected);
      end
   endtask

   // Line level during bit slot s of a frame carrying byte b.
   function automatic logic slotValue(input int s, input logic [7:0] b, input int par);
      logic [7:0] d;
      d = b;
      if (s == 0) return 1'b0;
      if (s <= 8) return d[s-1];
      if (s == 9 && par != 0) return (par == 2) ? (^d) : ~(^d);
      return 1'b1;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_cfg
      localparam int C     = (g == 0) ? 4 : (g == 1) ? 5 : 7;
      localparam int PAR   = (g == 0) ? 0 : (g == 1) ? 2 : 1;
      localparam int STOPS = (g == 0) ? 1 : 2;
      localparam int F     = C * (9 + ((PAR != 0) ? 1 : 0) + STOPS);

      logic       rst;
      logic       dv;
      logic [7:0] txByte;
      logic       ser, act, rdy, dn;

      uart_tx #(
         .CLKS_PER_BIT(C),
         .PARITY      (PAR),
         .STOP_BITS   (STOPS)
      ) dut (
         .i_Clock    (clk),
         .i_Reset    (rst),
         .i_TX_DV    (dv),
         .i_TX_Byte  (txByte),
         .o_TX_Serial(ser),
         .o_TX_Active(act),
         .o_TX_Ready (rdy),
         .o_TX_Done  (dn)
      );

      exp_t expq[$];
      logic wave[$];
      exp_t monE;
      int   mism;
      int   doneSeen = 0;
      int   accepted = 0;
      int   aborted  = 0;

      // Monitor: capture the line while active, score the frame on each Done pulse.
      always @(negedge clk) begin
         if (rst) begin
            wave.delete();
         end else begin
            if (act) wave.push_back(ser);
            if (dn) begin
               doneSeen++;
               if (expq.size() == 0) begin
                  checkOutput("spurious_done", g, 1, 0);
               end else begin
                  monE = expq.pop_front();
                  checkOutput("done_cycle", g, cyc, monE.n + F);
                  checkOutput("frame_len", g, wave.size(), F);
                  mism = 0;
                  foreach (wave[i]) begin
                     if (wave[i] !== slotValue(i / C, monE.b, PAR)) mism++;
                  end
                  checkOutput("frame_bits", g, mism, 0);
                  checkOutput("done_line", g, {act, ser}, 1);
               end
               wave.delete();
            end
         end
      end

      // Stimulus and timing model: a byte is taken only when the previous frame
      // (F cycles plus the cleanup cycle) has fully finished.
      initial begin : applyStimulus
         int  e;
         int  lastN;
         int  mode;
         bit  busy;
         bit  modelReady;
         bit  resetPending;
         busy = 0;
         lastN = 0;
         resetPending = 0;
         rst = 1'b1;
         dv = 1'b0;
         txByte = 8'h00;
         repeat (3) @(posedge clk);
         #1;
         checkOutput("reset_state", g, {ser, act, rdy, dn}, 4'b1010);
         rst = 1'b0;
         for (int k = 0; k < 2400; k++) begin
            @(posedge clk);
            #1;
            e = cyc;
            if (resetPending) begin
               resetPending = 0;
               busy = 0;
               aborted += expq.size();
               expq.delete();
               checkOutput("reset_abort", g, {ser, act, rdy, dn}, 4'b1010);
            end
            modelReady = !busy || (e >= lastN + F + 1);
            checkOutput("ready", g, rdy, modelReady);
            mode = (k / 300) % 3;
            rst = 1'b0;
            txByte = 8'($urandom_range(0, 255));
            if (k == 5) begin
               dv = 1'b1;
               txByte = (g == 0) ? 8'h37 : 8'hA5;
            end else if (mode == 0) begin
               dv = ($urandom_range(0, 7) == 0);
            end else if (mode == 1) begin
               dv = 1'b1;
            end else begin
               dv = ($urandom_range(0, 5) == 0);
               if (busy && (e == lastN + 4 * C + 1) && ($urandom_range(0, 1) == 1)) begin
                  rst = 1'b1;
                  dv = 1'b1;
                  resetPending = 1;
               end
            end
            if (dv && !rst && modelReady) begin
               expq.push_back('{txByte, e + 1});
               busy = 1;
               lastN = e + 1;
               accepted++;
            end
         end
         @(posedge clk);
         #1;
         dv = 1'b0;
         rst = 1'b0;
         if (resetPending) begin
            aborted += expq.size();
            expq.delete();
         end
         repeat (F + 5) @(posedge clk);
         #1;
         checkOutput("queue_empty", g, expq.size(), 0);
         checkOutput("done_count", g, doneSeen, accepted - aborted);
         checkOutput("idle_state", g, {ser, act, rdy, dn}, 4'b1010);
         finishedCount++;
      end
   end

   initial begin : checkerMain
      int t;
      t = 0;
      while (finishedCount < 3 && t < 50000) begin
         @(posedge clk);
         t++;
      end
      if (finishedCount < 3) checkOutput("timeout", -1, finishedCount, 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
